// File: rtl/vga_ball_pkg.sv
// ---------------------------------------------------------------------------
// vga_ball_pkg
// Shared definitions for the VGA ball register file and frame scheduler:
// Avalon register addresses, the CTRL register layout, the scheduler FSM
// state type, the reset background colour and a position clamp helper.
// ---------------------------------------------------------------------------
package vga_ball_pkg;

   // Avalon register map.
   // FRAME is read-only and host writes to it are dropped.
   localparam logic [2:0] ADDR_BG_R  = 3'd0;
   localparam logic [2:0] ADDR_BG_G  = 3'd1;
   localparam logic [2:0] ADDR_BG_B  = 3'd2;
   localparam logic [2:0] ADDR_X     = 3'd3;
   localparam logic [2:0] ADDR_Y     = 3'd4;
   localparam logic [2:0] ADDR_CTRL  = 3'd5;
   localparam logic [2:0] ADDR_SPEED = 3'd6;
   localparam logic [2:0] ADDR_FRAME = 3'd7;

   // Number of writable registers.
   // Each writable register has one pending bit.
   localparam int NUM_WREGS = 7;

   // CTRL register layout, bit 2 down to bit 0.
   typedef struct packed {
      logic dyNeg;
      logic dxNeg;
      logic autoEn;
   } ctrl_t;

   // Frame scheduler states.
   // IDLE waits for the end of the last active line.
   // COMMIT copies shadows to the outputs.
   // MOVE runs the bounce engine.
   typedef enum logic [1:0] {
      IDLE,
      COMMIT,
      MOVE
   } state_t;

   // Background colour after reset is a dark blue.
   localparam logic [7:0] RESET_BG_R = 8'h00;
   localparam logic [7:0] RESET_BG_G = 8'h00;
   localparam logic [7:0] RESET_BG_B = 8'h80;

   // Clamp an 8-bit host value to the largest legal cell index of an axis.
   function automatic logic [5:0] clampPos(input logic [7:0] value,
                                           input logic [5:0] maxPos);
      logic [5:0] result;
      if (value > {2'b00, maxPos}) begin
         result = maxPos;
      end else begin
         result = value[5:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/vga_ball_axis.sv
// ---------------------------------------------------------------------------
// vga_ball_axis
// One axis of the ball: the committed cell position, the committed travel
// direction and the bounce step. Two copies of this block are used, one for
// columns and one for rows. The maximum cell index is set by MAX_POS.
//
// Ports
//   clk, reset      clock and asynchronous active-high reset
//   i_loadPos       load i_loadValue into the position (host commit)
//   i_loadValue     committed host position, already clamped
//   i_loadDir       load i_loadDirNeg into the direction (CTRL commit)
//   i_loadDirNeg    committed direction, 1 = towards zero
//   i_step          advance one cell, bouncing at the ends
//   o_pos           committed position
//   o_stepDirNeg    direction the axis will have after a step; the top
//                   copies this back into the CTRL shadow
// ---------------------------------------------------------------------------
module vga_ball_axis
   import vga_ball_pkg::*;
#(
   parameter logic [5:0] MAX_POS = 6'd39
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_loadPos,
   input  logic [5:0] i_loadValue,
   input  logic       i_loadDir,
   input  logic       i_loadDirNeg,
   input  logic       i_step,
   output logic [5:0] o_pos,
   output logic       o_stepDirNeg
);

   logic [5:0] r_pos;
   logic       r_dirNeg;
   logic [5:0] w_nextPos;
   logic       w_nextDirNeg;

   // Bounce step.
   // When the ball sits on an end cell and is still heading outward, it
   // reflects: it moves one cell back inward and the direction flips.
   // Otherwise it moves one cell in its current direction. The >= guard
   // keeps an out-of-range position moving back into range.
   always_comb begin
      w_nextPos    = r_pos;
      w_nextDirNeg = r_dirNeg;
      if (!r_dirNeg && (r_pos >= MAX_POS)) begin
         w_nextPos    = r_pos - 6'd1;
         w_nextDirNeg = 1'b1;
      end else if (r_dirNeg && (r_pos == 6'd0)) begin
         w_nextPos    = 6'd1;
         w_nextDirNeg = 1'b0;
      end else if (r_dirNeg) begin
         w_nextPos    = r_pos - 6'd1;
      end else begin
         w_nextPos    = r_pos + 6'd1;
      end
   end

   // Position and direction registers.
   // Host loads and motion steps happen in different scheduler states and
   // never coincide. The step is listed last so that it would take
   // priority if they ever did.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pos    <= 6'd0;
         r_dirNeg <= 1'b0;
      end else begin
         if (i_loadPos) begin
            r_pos <= i_loadValue;
         end
         if (i_loadDir) begin
            r_dirNeg <= i_loadDirNeg;
         end
         if (i_step) begin
            r_pos    <= w_nextPos;
            r_dirNeg <= w_nextDirNeg;
         end
      end
   end

   assign o_pos        = r_pos;
   assign o_stepDirNeg = w_nextDirNeg;

endmodule

// File: rtl/vga_ball_ctrl.sv
// ---------------------------------------------------------------------------
// vga_ball_ctrl
// Register file and frame scheduler for the VGA ball display. Host writes
// land in shadow registers and set a pending bit. Once per frame, at the
// end of the last active line, the pending shadows are committed together,
// so the picture never tears. The cycle after that, the bounce engine may
// step the ball.
//
// Ports
//   clk, reset              50 MHz clock, asynchronous active-high reset
//   i_chipselect, i_write,  Avalon slave: select, write and read strobes,
//   i_read, i_address,      register index, write data
//   i_writedata
//   o_readdata              registered read data, held between reads
//   i_hcount, i_vcount      beam position from vga_counters
//   o_bg_r/g/b              committed background colour
//   o_ball_x, o_ball_y      committed ball cell
//   o_frame_tick            one-cycle pulse on each commit
// ---------------------------------------------------------------------------
module vga_ball_ctrl
   import vga_ball_pkg::*;
#(
   parameter int HTOTAL  = 1600,
   parameter int VACTIVE = 480,
   parameter int XMAX    = 39,
   parameter int YMAX    = 29
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_chipselect,
   input  logic        i_write,
   input  logic        i_read,
   input  logic [2:0]  i_address,
   input  logic [7:0]  i_writedata,
   output logic [7:0]  o_readdata,
   input  logic [10:0] i_hcount,
   input  logic [9:0]  i_vcount,
   output logic [7:0]  o_bg_r,
   output logic [7:0]  o_bg_g,
   output logic [7:0]  o_bg_b,
   output logic [5:0]  o_ball_x,
   output logic [5:0]  o_ball_y,
   output logic        o_frame_tick
);

   state_t r_state;

   logic [7:0] r_shBgR;
   logic [7:0] r_shBgG;
   logic [7:0] r_shBgB;
   logic [5:0] r_shX;
   logic [5:0] r_shY;
   ctrl_t      r_shCtrl;
   logic [7:0] r_shSpeed;
   logic [NUM_WREGS-1:0] r_pending;
   logic [7:0] r_readdata;

   logic [7:0] r_bgR;
   logic [7:0] r_bgG;
   logic [7:0] r_bgB;
   logic       r_autoEn;
   logic [7:0] r_speed;
   logic [7:0] r_divider;
   logic [7:0] r_frameCount;
   logic       r_frameTick;
   logic       r_hostX;
   logic       r_hostY;
   logic       r_skipMove;

   logic       w_frameEvent;
   logic       w_hostWr;
   logic       w_hostRd;
   logic       w_inCommit;
   logic       w_inMove;
   logic       w_doStep;
   logic       w_stepX;
   logic       w_stepY;
   logic       w_enableRise;
   logic [7:0] w_commitSpeed;
   logic [7:0] w_readMux;
   logic [NUM_WREGS-1:0] w_writeMask;
   logic [5:0] w_xPos;
   logic [5:0] w_yPos;
   logic       w_xStepDirNeg;
   logic       w_yStepDirNeg;

   // The frame event is the last clock of the last active line. Vertical
   // blanking starts right after it, so committing here is tear-free.
   assign w_frameEvent = (i_hcount == 11'(HTOTAL - 1)) &&
                         (i_vcount == 10'(VACTIVE - 1));

   assign w_hostWr   = i_chipselect && i_write;
   assign w_hostRd   = i_chipselect && i_read;
   assign w_inCommit = (r_state == COMMIT);
   assign w_inMove   = (r_state == MOVE);

   // The bounce engine fires when the divider has run out. An axis whose
   // position the host committed this frame keeps the host value and does
   // not step.
   assign w_doStep = w_inMove && r_autoEn && !r_skipMove &&
                     (r_divider == 8'd0);
   assign w_stepX  = w_doStep && !r_hostX;
   assign w_stepY  = w_doStep && !r_hostY;

   // Turning auto-move on reloads the divider. If SPEED is committed in the
   // same frame, the new value is used for the reload.
   assign w_commitSpeed = r_pending[ADDR_SPEED] ? r_shSpeed : r_speed;
   assign w_enableRise  = r_pending[ADDR_CTRL] && r_shCtrl.autoEn &&
                          !r_autoEn;

   // One-hot decode of host writes onto the pending bits.
   // FRAME has no bit, so writes to it fall away here.
   always_comb begin
      w_writeMask = '0;
      for (int i = 0; i < NUM_WREGS; i++) begin
         w_writeMask[i] = w_hostWr && (i_address == 3'(i));
      end
   end

   // Readback source. Reads return shadow contents, not committed ones,
   // except FRAME, which returns the live frame counter.
   always_comb begin
      w_readMux = 8'd0;
      case (i_address)
         ADDR_BG_R:  w_readMux = r_shBgR;
         ADDR_BG_G:  w_readMux = r_shBgG;
         ADDR_BG_B:  w_readMux = r_shBgB;
         ADDR_X:     w_readMux = {2'b00, r_shX};
         ADDR_Y:     w_readMux = {2'b00, r_shY};
         ADDR_CTRL:  w_readMux = {5'b00000, r_shCtrl};
         ADDR_SPEED: w_readMux = r_shSpeed;
         default:    w_readMux = r_frameCount;
      endcase
   end

   // Host side: shadow registers, pending bits and read data.
   // COMMIT clears every pending bit. A write that lands in the COMMIT cycle
   // sets its bit again, so it waits for the next frame. Bounces during
   // MOVE copy the new direction into the CTRL shadow. A host CTRL write in
   // the same cycle overrides that copy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shBgR    <= RESET_BG_R;
         r_shBgG    <= RESET_BG_G;
         r_shBgB    <= RESET_BG_B;
         r_shX      <= 6'd0;
         r_shY      <= 6'd0;
         r_shCtrl   <= '0;
         r_shSpeed  <= 8'd0;
         r_pending  <= '0;
         r_readdata <= 8'd0;
      end else begin
         if (w_hostRd) begin
            r_readdata <= w_readMux;
         end
         r_pending <= (w_inCommit ? '0 : r_pending) | w_writeMask;
         if (w_writeMask[ADDR_BG_R]) begin
            r_shBgR <= i_writedata;
         end
         if (w_writeMask[ADDR_BG_G]) begin
            r_shBgG <= i_writedata;
         end
         if (w_writeMask[ADDR_BG_B]) begin
            r_shBgB <= i_writedata;
         end
         if (w_writeMask[ADDR_X]) begin
            r_shX <= clampPos(i_writedata, 6'(XMAX));
         end
         if (w_writeMask[ADDR_Y]) begin
            r_shY <= clampPos(i_writedata, 6'(YMAX));
         end
         if (w_writeMask[ADDR_SPEED]) begin
            r_shSpeed <= i_writedata;
         end
         if (w_writeMask[ADDR_CTRL]) begin
            r_shCtrl <= ctrl_t'(i_writedata[2:0]);
         end else begin
            if (w_stepX) begin
               r_shCtrl.dxNeg <= w_xStepDirNeg;
            end
            if (w_stepY) begin
               r_shCtrl.dyNeg <= w_yStepDirNeg;
            end
         end
      end
   end

   // Frame scheduler with its registered outputs.
   // IDLE waits for the frame event.
   // COMMIT copies pending shadows, pulses the tick, counts the frame and
   // records which axes the host owns this frame.
   // MOVE steps or counts down the divider and then returns to IDLE.
   // The frame in which auto-move is switched on only loads the divider,
   // so the first step comes SPEED+1 frames later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_bgR        <= RESET_BG_R;
         r_bgG        <= RESET_BG_G;
         r_bgB        <= RESET_BG_B;
         r_autoEn     <= 1'b0;
         r_speed      <= 8'd0;
         r_divider    <= 8'd0;
         r_frameCount <= 8'd0;
         r_frameTick  <= 1'b0;
         r_hostX      <= 1'b0;
         r_hostY      <= 1'b0;
         r_skipMove   <= 1'b0;
      end else begin
         r_frameTick <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_frameEvent) begin
                  r_state <= COMMIT;
               end
            end
            COMMIT: begin
               r_frameTick  <= 1'b1;
               r_frameCount <= r_frameCount + 8'd1;
               if (r_pending[ADDR_BG_R]) begin
                  r_bgR <= r_shBgR;
               end
               if (r_pending[ADDR_BG_G]) begin
                  r_bgG <= r_shBgG;
               end
               if (r_pending[ADDR_BG_B]) begin
                  r_bgB <= r_shBgB;
               end
               if (r_pending[ADDR_SPEED]) begin
                  r_speed <= r_shSpeed;
               end
               if (r_pending[ADDR_CTRL]) begin
                  r_autoEn <= r_shCtrl.autoEn;
               end
               if (w_enableRise) begin
                  r_divider <= w_commitSpeed;
               end
               r_skipMove <= w_enableRise;
               r_hostX    <= r_pending[ADDR_X];
               r_hostY    <= r_pending[ADDR_Y];
               r_state    <= MOVE;
            end
            MOVE: begin
               if (r_autoEn && !r_skipMove) begin
                  if (r_divider == 8'd0) begin
                     r_divider <= r_speed;
                  end else begin
                     r_divider <= r_divider - 8'd1;
                  end
               end
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Column axis. Its direction is the committed CTRL dx_neg bit.
   vga_ball_axis #(
      .MAX_POS (6'(XMAX))
   ) u_axisX (
      .clk          (clk),
      .reset        (reset),
      .i_loadPos    (w_inCommit && r_pending[ADDR_X]),
      .i_loadValue  (r_shX),
      .i_loadDir    (w_inCommit && r_pending[ADDR_CTRL]),
      .i_loadDirNeg (r_shCtrl.dxNeg),
      .i_step       (w_stepX),
      .o_pos        (w_xPos),
      .o_stepDirNeg (w_xStepDirNeg)
   );

   // Row axis. Its direction is the committed CTRL dy_neg bit.
   vga_ball_axis #(
      .MAX_POS (6'(YMAX))
   ) u_axisY (
      .clk          (clk),
      .reset        (reset),
      .i_loadPos    (w_inCommit && r_pending[ADDR_Y]),
      .i_loadValue  (r_shY),
      .i_loadDir    (w_inCommit && r_pending[ADDR_CTRL]),
      .i_loadDirNeg (r_shCtrl.dyNeg),
      .i_step       (w_stepY),
      .o_pos        (w_yPos),
      .o_stepDirNeg (w_yStepDirNeg)
   );

   assign o_readdata   = r_readdata;
   assign o_bg_r       = r_bgR;
   assign o_bg_g       = r_bgG;
   assign o_bg_b       = r_bgB;
   assign o_ball_x     = w_xPos;
   assign o_ball_y     = w_yPos;
   assign o_frame_tick = r_frameTick;

endmodule

// File: tb/tb_vga_ball_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_ball_ctrl
// Self-checking bench for vga_ball_ctrl. The bench drives hcount/vcount
// directly to place frame events where it wants them. It keeps a
// frame-level model of the register file and the ball, and compares the DUT
// against it after every commit, every move and every read.
// ---------------------------------------------------------------------------
module tb_vga_ball_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_chipselect;
   logic        i_write;
   logic        i_read;
   logic [2:0]  i_address;
   logic [7:0]  i_writedata;
   logic [7:0]  o_readdata;
   logic [10:0] i_hcount;
   logic [9:0]  i_vcount;
   logic [7:0]  o_bg_r;
   logic [7:0]  o_bg_g;
   logic [7:0]  o_bg_b;
   logic [5:0]  o_ball_x;
   logic [5:0]  o_ball_y;
   logic        o_frame_tick;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mSh [0:6];
   bit   [6:0] mPend;
   logic [7:0] mBg [0:2];
   int         mX;
   int         mY;
   bit         mDxNeg;
   bit         mDyNeg;
   bit         mAuto;
   int         mSpeed;
   int         mCount;
   int         mFrame;
   bit         mHostX;
   bit         mHostY;
   bit         mJustEn;

   always #10 clk = ~clk;

   vga_ball_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .i_chipselect (i_chipselect),
      .i_write      (i_write),
      .i_read       (i_read),
      .i_address    (i_address),
      .i_writedata  (i_writedata),
      .o_readdata   (o_readdata),
      .i_hcount     (i_hcount),
      .i_vcount     (i_vcount),
      .o_bg_r       (o_bg_r),
      .o_bg_g       (o_bg_g),
      .o_bg_b       (o_bg_b),
      .o_ball_x     (o_ball_x),
      .o_ball_y     (o_ball_y),
      .o_frame_tick (o_frame_tick)
   );

   // Count one comparison and report it when the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Model state after reset.
   function automatic void modelReset();
      for (int i = 0; i < 7; i++) begin
         mSh[i] = 8'h00;
      end
      mSh[2]  = 8'h80;
      mBg[0]  = 8'h00;
      mBg[1]  = 8'h00;
      mBg[2]  = 8'h80;
      mPend   = '0;
      mX      = 0;
      mY      = 0;
      mDxNeg  = 1'b0;
      mDyNeg  = 1'b0;
      mAuto   = 1'b0;
      mSpeed  = 0;
      mCount  = 0;
      mFrame  = 0;
      mHostX  = 1'b0;
      mHostY  = 1'b0;
      mJustEn = 1'b0;
   endfunction

   // A host write in the model: clamp X and Y, keep only three CTRL bits,
   // mark the register pending. FRAME ignores writes.
   function automatic void modelWrite(input int a, input int d);
      if (a == 7) begin
         return;
      end
      case (a)
         3:       mSh[a] = 8'((d > 39) ? 39 : d);
         4:       mSh[a] = 8'((d > 29) ? 29 : d);
         5:       mSh[a] = 8'(d % 8);
         default: mSh[a] = 8'(d);
      endcase
      mPend[a] = 1'b1;
   endfunction

   function automatic logic [7:0] modelRead(input int a);
      if (a == 7) begin
         return 8'(mFrame);
      end
      return mSh[a];
   endfunction

   // One cell of motion with reflection off the walls 0 and maxPos.
   function automatic void bounceStep(inout int pos, inout bit neg,
                                      input int maxPos);
      int nxt;
      nxt = pos + (neg ? -1 : 1);
      if (nxt > maxPos) begin
         nxt = maxPos - 1;
         neg = 1'b1;
      end else if (nxt < 0) begin
         nxt = 1;
         neg = 1'b0;
      end
      pos = nxt;
   endfunction

   // Frame commit: everything pending becomes visible at once.
   function automatic void modelCommit();
      mHostX  = mPend[3];
      mHostY  = mPend[4];
      mJustEn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (mPend[i]) begin
            mBg[i] = mSh[i];
         end
      end
      if (mPend[3]) mX = int'(mSh[3]);
      if (mPend[4]) mY = int'(mSh[4]);
      if (mPend[6]) mSpeed = int'(mSh[6]);
      if (mPend[5]) begin
         if (mSh[5][0] && !mAuto) begin
            mJustEn = 1'b1;
            mCount  = mSpeed + 1;
         end
         mAuto  = mSh[5][0];
         mDxNeg = mSh[5][1];
         mDyNeg = mSh[5][2];
      end
      mPend  = '0;
      mFrame = (mFrame + 1) % 256;
   endfunction

   // Motion: one step every SPEED+1 frames, starting SPEED+1 frames after
   // enabling. An axis the host committed this frame keeps the host value.
   function automatic void modelMove();
      if (mAuto && !mJustEn) begin
         mCount--;
         if (mCount == 0) begin
            mCount = mSpeed + 1;
            if (!mHostX) begin
               bounceStep(mX, mDxNeg, 39);
               mSh[5][1] = mDxNeg;
            end
            if (!mHostY) begin
               bounceStep(mY, mDyNeg, 29);
               mSh[5][2] = mDyNeg;
            end
         end
      end
   endfunction

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hostWrite(input int a, input int d);
      i_chipselect = 1'b1;
      i_write      = 1'b1;
      i_address    = 3'(a);
      i_writedata  = 8'(d);
      @(posedge clk);
      #1;
      i_chipselect = 1'b0;
      i_write      = 1'b0;
      modelWrite(a, d);
   endtask

   task automatic hostRead(input int a, input string tag);
      logic [7:0] expected;
      expected     = modelRead(a);
      i_chipselect = 1'b1;
      i_read       = 1'b1;
      i_address    = 3'(a);
      @(posedge clk);
      #1;
      i_chipselect = 1'b0;
      i_read       = 1'b0;
      checkOutput(tag, o_readdata, expected);
   endtask

   // Drive one frame event and check the commit and move cycles.
   // With cw set, a host write is driven during the COMMIT cycle.
   task automatic runFrame(input bit cw, input int ca, input int cd);
      i_hcount = 11'd1599;
      i_vcount = 10'd479;
      @(posedge clk);
      #1;
      i_hcount = 11'd0;
      i_vcount = 10'd0;
      checkOutput("preCommitTick", o_frame_tick, 0);
      checkOutput("preCommitX", o_ball_x, mX);
      checkOutput("preCommitY", o_ball_y, mY);
      if (cw) begin
         i_chipselect = 1'b1;
         i_write      = 1'b1;
         i_address    = 3'(ca);
         i_writedata  = 8'(cd);
      end
      @(posedge clk);
      #1;
      i_chipselect = 1'b0;
      i_write      = 1'b0;
      modelCommit();
      if (cw) begin
         modelWrite(ca, cd);
      end
      checkOutput("commitTick", o_frame_tick, 1);
      checkOutput("commitX", o_ball_x, mX);
      checkOutput("commitY", o_ball_y, mY);
      checkOutput("commitBgR", o_bg_r, mBg[0]);
      checkOutput("commitBgG", o_bg_g, mBg[1]);
      checkOutput("commitBgB", o_bg_b, mBg[2]);
      @(posedge clk);
      #1;
      modelMove();
      checkOutput("moveTick", o_frame_tick, 0);
      checkOutput("moveX", o_ball_x, mX);
      checkOutput("moveY", o_ball_y, mY);
   endtask

   // One randomized frame: a few host writes and reads, a random number of
   // idle cycles, sometimes a write in the COMMIT cycle, the frame event,
   // and finally a FRAME counter read.
   task automatic applyStimulus();
      int nOps;
      int a;
      int d;
      nOps = $urandom_range(0, 3);
      for (int k = 0; k < nOps; k++) begin
         a = $urandom_range(0, 7);
         if ($urandom_range(0, 9) < 7) begin
            case (a)
               3:       d = $urandom_range(0, 63);
               4:       d = $urandom_range(0, 40);
               5:       d = $urandom_range(0, 7);
               6:       d = $urandom_range(0, 3);
               default: d = $urandom_range(0, 255);
            endcase
            hostWrite(a, d);
         end else begin
            hostRead(a, "randRead");
         end
      end
      idleCycles($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) begin
         runFrame(1'b1, $urandom_range(0, 7), $urandom_range(0, 63));
      end else begin
         runFrame(1'b0, 0, 0);
      end
      hostRead(7, "frameCount");
   endtask

   initial begin
      int prevX;
      int changes;

      reset        = 1'b1;
      i_chipselect = 1'b0;
      i_write      = 1'b0;
      i_read       = 1'b0;
      i_address    = 3'd0;
      i_writedata  = 8'd0;
      i_hcount     = 11'd0;
      i_vcount     = 10'd0;
      modelReset();
      idleCycles(3);
      checkOutput("rstX", o_ball_x, 0);
      checkOutput("rstY", o_ball_y, 0);
      checkOutput("rstTick", o_frame_tick, 0);
      checkOutput("rstBgB", o_bg_b, 8'h80);
      checkOutput("rstRead", o_readdata, 0);
      reset = 1'b0;
      idleCycles(1);

      hostRead(0, "readBgR");
      checkOutput("readBgRConst", o_readdata, 8'h00);
      hostRead(1, "readBgG");
      checkOutput("readBgGConst", o_readdata, 8'h00);
      hostRead(2, "readBgB");
      checkOutput("readBgBConst", o_readdata, 8'h80);
      hostWrite(2, 8'h11);
      checkOutput("readHold", o_readdata, 8'h80);

      hostWrite(3, 5);
      idleCycles(3);
      checkOutput("xBeforeFrame", o_ball_x, 0);
      runFrame(1'b0, 0, 0);
      checkOutput("x5", o_ball_x, 5);
      checkOutput("bgBCommitted", o_bg_b, 8'h11);
      hostWrite(3, 50);
      runFrame(1'b0, 0, 0);
      checkOutput("xClamp", o_ball_x, 39);
      hostRead(3, "readXClamp");

      i_hcount = 11'd1599;
      i_vcount = 10'd478;
      idleCycles(1);
      checkOutput("nearMissTick0", o_frame_tick, 0);
      i_hcount = 11'd1598;
      i_vcount = 10'd479;
      idleCycles(1);
      checkOutput("nearMissTick1", o_frame_tick, 0);
      i_hcount = 11'd0;
      i_vcount = 10'd0;
      idleCycles(1);
      checkOutput("nearMissTick2", o_frame_tick, 0);
      hostRead(7, "nearMissFrame");

      hostWrite(5, 1);
      hostWrite(6, 0);
      hostWrite(3, 38);
      runFrame(1'b0, 0, 0);
      checkOutput("bounce38", o_ball_x, 38);
      runFrame(1'b0, 0, 0);
      checkOutput("bounce39", o_ball_x, 39);
      runFrame(1'b0, 0, 0);
      checkOutput("bounceBack38", o_ball_x, 38);
      runFrame(1'b0, 0, 0);
      checkOutput("bounce37", o_ball_x, 37);
      hostRead(5, "ctrlAfterBounce");
      checkOutput("ctrlDxNeg", o_readdata, 8'h03);

      hostWrite(3, 10);
      runFrame(1'b0, 0, 0);
      checkOutput("hostWinsX", o_ball_x, 10);
      checkOutput("yStillSteps", o_ball_y, 4);

      hostWrite(5, 0);
      runFrame(1'b0, 0, 0);
      hostWrite(6, 2);
      hostWrite(5, 1);
      runFrame(1'b0, 0, 0);
      changes = 0;
      for (int f = 0; f < 6; f++) begin
         prevX = int'(o_ball_x);
         runFrame(1'b0, 0, 0);
         if (int'(o_ball_x) != prevX) begin
            changes++;
         end
      end
      checkOutput("speed2Changes", changes, 2);
      checkOutput("speed2X", o_ball_x, 12);

      hostWrite(5, 0);
      runFrame(1'b0, 0, 0);
      runFrame(1'b1, 3, 7);
      checkOutput("commitWrNotYet", o_ball_x, 12);
      runFrame(1'b0, 0, 0);
      checkOutput("commitWrLater", o_ball_x, 7);

      for (int f = 0; f < 300; f++) begin
         applyStimulus();
      end

      hostWrite(3, 20);
      #4;
      reset = 1'b1;
      #2;
      checkOutput("midRstX", o_ball_x, 0);
      checkOutput("midRstY", o_ball_y, 0);
      checkOutput("midRstTick", o_frame_tick, 0);
      checkOutput("midRstBgR", o_bg_r, 8'h00);
      checkOutput("midRstBgG", o_bg_g, 8'h00);
      checkOutput("midRstBgB", o_bg_b, 8'h80);
      checkOutput("midRstRead", o_readdata, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      modelReset();
      idleCycles(2);
      runFrame(1'b0, 0, 0);
      checkOutput("rstDropsWrite", o_ball_x, 0);
      hostRead(3, "rstShadowX");
      checkOutput("rstShadowXConst", o_readdata, 0);
      hostRead(7, "rstFrame");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_ball_ctrl.md
Name: vga_ball_ctrl

Overview:
Register file and frame scheduler for the VGA ball display. It owns the background colour and ball-cell position, and arbitrates position updates between Avalon host writes and an autonomous bounce engine. Host writes land in shadow registers and are committed atomically once per frame, during vertical blanking, so the display never tears. It sits between the Avalon slave port and the pixel generator, and is driven by the hcount/vcount from vga_counters.

Parameters:
HTOTAL, 1600, clk50 cycles per line
VACTIVE, 480, active lines per frame
XMAX, 39, largest ball column (32-cycle cells: 1280/32-1)
YMAX, 29, largest ball row (16-line cells: 480/16-1)

Ports:
clk  in  1  50 MHz clock
reset  in  1  asynchronous, active-high
chipselect  in  1  Avalon select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  3  register index
writedata  in  8  write data
readdata  out  8  registered read data
hcount  in  11  horizontal count from vga_counters
vcount  in  10  vertical count from vga_counters
bg_r, bg_g, bg_b  out  8 each  committed background colour
ball_x  out  6  committed ball column
ball_y  out  6  committed ball row
frame_tick  out  1  one-cycle pulse on each commit

Behaviour:
- Register map (write to shadow): 0 BG_R, 1 BG_G, 2 BG_B, 3 X, 4 Y, 5 CTRL[2:0] = {dy_neg, dx_neg, auto_en}, 6 SPEED (frames per step minus 1). Address 7 is read-only FRAME (8-bit frame count); writes to it are ignored.
- Each write sets that register's pending bit. X/Y writes above XMAX/YMAX clamp to XMAX/YMAX on write.
- Reads: readdata <= shadow value (FRAME: counter) one cycle after chipselect&&read; otherwise it holds.
- Frame event: hcount==HTOTAL-1 && vcount==VACTIVE-1, i.e. the last cycle of the last active line.
- FSM states: IDLE, COMMIT, MOVE.
  - IDLE -> COMMIT on the frame event.
  - COMMIT (1 cycle): copy every pending shadow to its output register and clear the pending bits. Pulse frame_tick. Increment FRAME (wraps 255->0). Go to MOVE.
  - MOVE (1 cycle): if auto_en and divider==0, step the ball and reload divider=SPEED; else if auto_en, decrement the divider. Go to IDLE.
- Step and bounce, per axis:
  - dir + and pos==max: pos-1, dir flips to -.
  - dir - and pos==0: pos+1, dir flips to +.
  - Otherwise pos ±1.
  - The updated direction is written back to both the CTRL shadow and the committed CTRL.
- Arbitration: a host value committed for X (or Y) in this frame's COMMIT suppresses the motion step on that axis in the following MOVE; the host wins.
- Write in the same cycle as COMMIT: the write is stored in the shadow and its pending bit stays set, so it is applied next frame. A write during MOVE behaves the same way.
- auto_en 0->1 commit: divider loads SPEED and the first step occurs SPEED+1 frames later. auto_en=0 freezes motion.
- Reset (async), values:
  - bg = 00/00/80, x=y=0, CTRL=0, SPEED=0.
  - FRAME=0, divider=0, pending=0.
  - readdata=0, frame_tick=0, state IDLE.
- Reset mid-frame discards pending writes.
- Arithmetic is 6-bit for positions and 8-bit for divider/FRAME; no wider intermediates are needed.

Decomposition:
- Package vga_ball_pkg:
  - Register address localparams (ADDR_BG_R..ADDR_FRAME).
  - ctrl_t packed struct {dy_neg, dx_neg, auto_en}.
  - state_t enum {IDLE, COMMIT, MOVE}.
  - Reset colour constants.
- One sub-module: vga_ball_axis, instantiated twice. It holds position, direction and the bounce step for one axis, with the max as a parameter.

Test Plan:
- Reset, then read addresses 0-2 -> 00, 00, 80. ball_x=ball_y=0, frame_tick low.
- Write X=5 mid-frame -> ball_x stays 0 until the frame event, becomes 5 two cycles later, with frame_tick high that cycle. Write X=50 -> ball_x becomes 39 after commit.
- CTRL=1, SPEED=0, X=38 -> successive frames give ball_x 39, 38, 37. CTRL readback shows dx_neg=1 after the bounce.
- SPEED=2, auto_en -> position changes once every 3 frames. FRAME reads increment by 1 per frame and wrap 255->0.
- Auto-move on, host writes X=10 during a frame -> ball_x=10 after commit with no step on X that frame. Y still steps.
- Write asserted exactly in the COMMIT cycle -> value appears one frame later. Assert reset mid-frame with a pending write -> outputs return to reset values and the write is never applied.
